// File: rtl/kpg_pipe_adder.sv
// Pipelined Kogge-Stone KPG adder/subtractor with valid/ready handshake.
// Carry-in is folded into bit 0, so ceil(log2(WIDTH)) combine levels suffice.
module kpg_pipe_adder #(
    parameter int WIDTH         = 24,
    parameter int LVL_PER_STAGE = 2,
    parameter int TAG_W         = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       k_in,
    input  logic             sub,
    input  logic [TAG_W-1:0] tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int NPS    = (LEVELS + LVL_PER_STAGE - 1) / LVL_PER_STAGE;

    logic             en;
    logic [WIDTH-1:0] bEff;
    logic [WIDTH-1:0] genIn;
    logic [WIDTH-1:0] propIn;
    logic             cinIn;

    logic [WIDTH-1:0] gReg   [NPS];
    logic [WIDTH-1:0] pReg   [NPS];
    logic [WIDTH-1:0] hsReg  [NPS];
    logic             cinReg [NPS];
    logic [TAG_W-1:0] tagReg [NPS];
    logic [NPS-1:0]   vReg;

    logic [WIDTH-1:0] gNext  [NPS];
    logic [WIDTH-1:0] pNext  [NPS];
    logic [WIDTH-1:0] gLast;
    logic [WIDTH-1:0] carry;
    logic [WIDTH:0]   sumNext;

    assign en       = ~out_valid | out_ready;
    assign in_ready = en;
    assign busy     = (|vReg) | out_valid;

    // Per-bit generate/propagate, with the carry-in absorbed into bit 0
    always_comb begin
        bEff     = sub ? ~b : b;
        cinIn    = sub | k_in[1] | k_in[0];
        genIn    = a & bEff;
        propIn   = a ^ bEff;
        genIn[0] = genIn[0] | (propIn[0] & cinIn);
    end

    // Prefix combine: stage s applies the levels assigned to its group
    always_comb begin : prefix
        logic [WIDTH-1:0] gv;
        logic [WIDTH-1:0] pv;
        logic [WIDTH-1:0] gt;
        logic [WIDTH-1:0] pt;
        gv = '0;
        pv = '0;
        gt = '0;
        pt = '0;
        for (int s = 0; s < NPS; s++) begin
            gv = gReg[s];
            pv = pReg[s];
            for (int l = 0; l < LEVELS; l++) begin
                if (l / LVL_PER_STAGE == s) begin
                    gt = gv;
                    pt = pv;
                    for (int i = 0; i < WIDTH; i++) begin
                        if (i >= (1 << l)) begin
                            gt[i] = gv[i] | (pv[i] & gv[i-(1<<l)]);
                            pt[i] = pv[i] & pv[i-(1<<l)];
                        end
                    end
                    gv = gt;
                    pv = pt;
                end
            end
            gNext[s] = gv;
            pNext[s] = pv;
        end
    end

    // Final sum from group generates; bit 0 carry is the raw carry-in
    always_comb begin
        gLast   = gNext[NPS-1];
        carry   = {gLast[WIDTH-2:0], cinReg[NPS-1]};
        sumNext = {gLast[WIDTH-1], hsReg[NPS-1] ^ carry};
    end

    // Pipeline registers: all stages advance together or hold together
    always_ff @(posedge clk) begin
        if (reset) begin
            vReg      <= '0;
            out_valid <= 1'b0;
            sum       <= '0;
            out_tag   <= '0;
            for (int s = 0; s < NPS; s++) begin
                gReg[s]   <= '0;
                pReg[s]   <= '0;
                hsReg[s]  <= '0;
                cinReg[s] <= 1'b0;
                tagReg[s] <= '0;
            end
        end else if (en) begin
            vReg[0]   <= in_valid;
            gReg[0]   <= genIn;
            pReg[0]   <= {propIn[WIDTH-1:1], 1'b0};
            hsReg[0]  <= propIn;
            cinReg[0] <= cinIn;
            tagReg[0] <= tag;
            for (int s = 1; s < NPS; s++) begin
                vReg[s]   <= vReg[s-1];
                gReg[s]   <= gNext[s-1];
                pReg[s]   <= pNext[s-1];
                hsReg[s]  <= hsReg[s-1];
                cinReg[s] <= cinReg[s-1];
                tagReg[s] <= tagReg[s-1];
            end
            out_valid <= vReg[NPS-1];
            sum       <= sumNext;
            out_tag   <= tagReg[NPS-1];
        end
    end

endmodule
